// File: rtl/axi_xbar_pkg.sv
// Shared crossbar types: master tags, arbiter state encoding and the latched AR packet.
package axi_xbar_pkg;

  localparam logic [3:0] TAG_M0 = 4'b0001;
  localparam logic [3:0] TAG_M1 = 4'b0010;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } state_t;

  typedef struct packed {
    logic [7:0]  id;
    logic [31:0] addr;
    logic [3:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
  } ar_pkt_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; the priority pointer moves to the loser only when a grant is accepted.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       accept,
  output logic       gnt,
  output logic       gnt_valid
);

  logic ptr_r;

  // Grant selection: a lone requester wins, a tie goes to the pointer.
  always_comb begin
    gnt_valid = |req;
    if (req == 2'b11) begin
      gnt = ptr_r;
    end else if (req[1]) begin
      gnt = 1'b1;
    end else begin
      gnt = 1'b0;
    end
  end

  // Pointer update on an accepted grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_r <= 1'b0;
    end else if (accept && gnt_valid) begin
      ptr_r <= ~gnt;
    end else begin
      ptr_r <= ptr_r;
    end
  end

endmodule

// File: rtl/axi_rd_arbiter.sv
// Per-slave AXI read arbiter: shares one slave AR/R port between M0 and M1, one burst at a time.
module axi_rd_arbiter
  import axi_xbar_pkg::*;
#(
  parameter int ID_W   = 4,
  parameter int IDS_W  = 8,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int LEN_W  = 4,
  parameter int SIZE_W = 3
) (
  input  logic              AXI_CLK_i,
  input  logic              AXI_RST_i,
  input  logic [ID_W-1:0]   ARID_M0_i,
  input  logic [ADDR_W-1:0] ARADDR_M0_i,
  input  logic [LEN_W-1:0]  ARLEN_M0_i,
  input  logic [SIZE_W-1:0] ARSIZE_M0_i,
  input  logic [1:0]        ARBURST_M0_i,
  input  logic              ARVALID_M0_i,
  output logic              ARREADY_M0_o,
  output logic [ID_W-1:0]   RID_M0_o,
  output logic [DATA_W-1:0] RDATA_M0_o,
  output logic [1:0]        RRESP_M0_o,
  output logic              RLAST_M0_o,
  output logic              RVALID_M0_o,
  input  logic              RREADY_M0_i,
  input  logic [ID_W-1:0]   ARID_M1_i,
  input  logic [ADDR_W-1:0] ARADDR_M1_i,
  input  logic [LEN_W-1:0]  ARLEN_M1_i,
  input  logic [SIZE_W-1:0] ARSIZE_M1_i,
  input  logic [1:0]        ARBURST_M1_i,
  input  logic              ARVALID_M1_i,
  output logic              ARREADY_M1_o,
  output logic [ID_W-1:0]   RID_M1_o,
  output logic [DATA_W-1:0] RDATA_M1_o,
  output logic [1:0]        RRESP_M1_o,
  output logic              RLAST_M1_o,
  output logic              RVALID_M1_o,
  input  logic              RREADY_M1_i,
  output logic [IDS_W-1:0]  ARID_S_o,
  output logic [ADDR_W-1:0] ARADDR_S_o,
  output logic [LEN_W-1:0]  ARLEN_S_o,
  output logic [SIZE_W-1:0] ARSIZE_S_o,
  output logic [1:0]        ARBURST_S_o,
  output logic              ARVALID_S_o,
  input  logic              ARREADY_S_i,
  input  logic [IDS_W-1:0]  RID_S_i,
  input  logic [DATA_W-1:0] RDATA_S_i,
  input  logic [1:0]        RRESP_S_i,
  input  logic              RLAST_S_i,
  input  logic              RVALID_S_i,
  output logic              RREADY_S_o
);

  state_t  state_r, state_next;
  logic    owner_r;
  ar_pkt_t pkt_r, pkt_next;
  logic [1:0] req;
  logic    gnt, gnt_valid, ar_accept, r_done;
  logic    unused_rid_tag;

  // Routing uses the owner only, so the slave-side tag bits are intentionally ignored.
  assign unused_rid_tag = ^RID_S_i[IDS_W-1:ID_W];

  // Requests are masked during reset so no ARREADY can leak out while AXI_RST_i is low.
  assign req       = {ARVALID_M1_i, ARVALID_M0_i} & {2{AXI_RST_i}};
  assign ar_accept = (state_r == IDLE) && gnt_valid;
  assign r_done    = (state_r == DATA) && RVALID_S_i && RREADY_S_o && RLAST_S_i;

  rr_arb2 u_rr_arb2 (
    .clk       (AXI_CLK_i),
    .rst_n     (AXI_RST_i),
    .req       (req),
    .accept    (ar_accept),
    .gnt       (gnt),
    .gnt_valid (gnt_valid)
  );

  // State register.
  always_ff @(posedge AXI_CLK_i or negedge AXI_RST_i) begin
    if (!AXI_RST_i) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state_r;
    case (state_r)
      IDLE:    if (ar_accept) state_next = ADDR; else state_next = IDLE;
      ADDR:    if (ARREADY_S_i) state_next = DATA; else state_next = ADDR;
      DATA:    if (r_done) state_next = IDLE; else state_next = DATA;
      default: state_next = IDLE;
    endcase
  end

  // Tagged AR packet of the currently granted master.
  always_comb begin
    if (gnt) begin
      pkt_next = '{id: {TAG_M1, ARID_M1_i}, addr: ARADDR_M1_i, len: ARLEN_M1_i,
                   size: ARSIZE_M1_i, burst: ARBURST_M1_i};
    end else begin
      pkt_next = '{id: {TAG_M0, ARID_M0_i}, addr: ARADDR_M0_i, len: ARLEN_M0_i,
                   size: ARSIZE_M0_i, burst: ARBURST_M0_i};
    end
  end

  // AR field latch and burst owner, captured on the master handshake.
  always_ff @(posedge AXI_CLK_i or negedge AXI_RST_i) begin
    if (!AXI_RST_i) begin
      pkt_r   <= '0;
      owner_r <= 1'b0;
    end else if (ar_accept) begin
      pkt_r   <= pkt_next;
      owner_r <= gnt;
    end else begin
      pkt_r   <= pkt_r;
      owner_r <= owner_r;
    end
  end

  assign ARID_S_o    = pkt_r.id;
  assign ARADDR_S_o  = pkt_r.addr;
  assign ARLEN_S_o   = pkt_r.len;
  assign ARSIZE_S_o  = pkt_r.size;
  assign ARBURST_S_o = pkt_r.burst;

  // Handshake outputs and R-channel steering to the owner.
  always_comb begin
    ARREADY_M0_o = 1'b0;
    ARREADY_M1_o = 1'b0;
    ARVALID_S_o  = 1'b0;
    RREADY_S_o   = 1'b0;
    RVALID_M0_o  = 1'b0;
    RVALID_M1_o  = 1'b0;
    RID_M0_o     = '0;
    RDATA_M0_o   = '0;
    RRESP_M0_o   = 2'b00;
    RLAST_M0_o   = 1'b0;
    RID_M1_o     = '0;
    RDATA_M1_o   = '0;
    RRESP_M1_o   = 2'b00;
    RLAST_M1_o   = 1'b0;
    case (state_r)
      IDLE: begin
        ARREADY_M0_o = gnt_valid && !gnt;
        ARREADY_M1_o = gnt_valid && gnt;
      end
      ADDR: ARVALID_S_o = 1'b1;
      DATA: begin
        if (owner_r) begin
          RVALID_M1_o = RVALID_S_i;
          RREADY_S_o  = RREADY_M1_i;
          RID_M1_o    = RID_S_i[ID_W-1:0];
          RDATA_M1_o  = RDATA_S_i;
          RRESP_M1_o  = RRESP_S_i;
          RLAST_M1_o  = RLAST_S_i;
        end else begin
          RVALID_M0_o = RVALID_S_i;
          RREADY_S_o  = RREADY_M0_i;
          RID_M0_o    = RID_S_i[ID_W-1:0];
          RDATA_M0_o  = RDATA_S_i;
          RRESP_M0_o  = RRESP_S_i;
          RLAST_M0_o  = RLAST_S_i;
        end
      end
      default: ARVALID_S_o = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Directed plus randomized bench for axi_rd_arbiter against a round-robin burst-level reference model.
module tb_axi_rd_arbiter;
  import axi_xbar_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [3:0]  arid   [2];
  logic [31:0] araddr [2];
  logic [3:0]  arlen  [2];
  logic [2:0]  arsize [2];
  logic [1:0]  arburst[2];
  logic [1:0]  arvalid, arready, rvalid_m, rlast_m, rready;
  logic [3:0]  rid_m  [2];
  logic [31:0] rdata_m[2];
  logic [1:0]  rresp_m[2];
  logic [7:0]  arid_s;
  logic [31:0] araddr_s;
  logic [3:0]  arlen_s;
  logic [2:0]  arsize_s;
  logic [1:0]  arburst_s;
  logic        arvalid_s, arready_s, rready_s;
  logic [7:0]  rid_s;
  logic [31:0] rdata_s;
  logic [1:0]  rresp_s;
  logic        rlast_s, rvalid_s;

  int n_chk = 0;
  int n_fail = 0;
  int prio = 0;  // reference model: which master wins a tie

  axi_rd_arbiter dut (
    .AXI_CLK_i(clk), .AXI_RST_i(rst_n),
    .ARID_M0_i(arid[0]), .ARADDR_M0_i(araddr[0]), .ARLEN_M0_i(arlen[0]),
    .ARSIZE_M0_i(arsize[0]), .ARBURST_M0_i(arburst[0]), .ARVALID_M0_i(arvalid[0]),
    .ARREADY_M0_o(arready[0]), .RID_M0_o(rid_m[0]), .RDATA_M0_o(rdata_m[0]),
    .RRESP_M0_o(rresp_m[0]), .RLAST_M0_o(rlast_m[0]), .RVALID_M0_o(rvalid_m[0]),
    .RREADY_M0_i(rready[0]),
    .ARID_M1_i(arid[1]), .ARADDR_M1_i(araddr[1]), .ARLEN_M1_i(arlen[1]),
    .ARSIZE_M1_i(arsize[1]), .ARBURST_M1_i(arburst[1]), .ARVALID_M1_i(arvalid[1]),
    .ARREADY_M1_o(arready[1]), .RID_M1_o(rid_m[1]), .RDATA_M1_o(rdata_m[1]),
    .RRESP_M1_o(rresp_m[1]), .RLAST_M1_o(rlast_m[1]), .RVALID_M1_o(rvalid_m[1]),
    .RREADY_M1_i(rready[1]),
    .ARID_S_o(arid_s), .ARADDR_S_o(araddr_s), .ARLEN_S_o(arlen_s),
    .ARSIZE_S_o(arsize_s), .ARBURST_S_o(arburst_s), .ARVALID_S_o(arvalid_s),
    .ARREADY_S_i(arready_s), .RID_S_i(rid_s), .RDATA_S_i(rdata_s),
    .RRESP_S_i(rresp_s), .RLAST_S_i(rlast_s), .RVALID_S_i(rvalid_s),
    .RREADY_S_o(rready_s)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic new_fields(input int m, input int len);
    arid[m]    = 4'($urandom);
    araddr[m]  = $urandom;
    arlen[m]   = 4'(len);
    arsize[m]  = 3'($urandom);
    arburst[m] = 2'($urandom);
  endtask

  // Reset takes effect mid-cycle, away from any clock edge, and is released after two edges.
  task automatic async_reset(input bit keep_m1_req);
    #2;
    rst_n = 1'b0;
    if (keep_m1_req) begin
      new_fields(1, 2);
      arvalid[1] = 1'b1;
    end
    #1;
    chk("rst_arvalid_s", arvalid_s, 1'b0);
    chk("rst_rready_s", rready_s, 1'b0);
    chk("rst_rvalid_m", rvalid_m, 2'b00);
    chk("rst_arready_m", arready, 2'b00);
    chk("rst_araddr_s", araddr_s, 32'h0);
    chk("rst_arid_s", arid_s, 8'h00);
    chk("rst_arlen_s", arlen_s, 4'h0);
    rvalid_s = 1'b0;
    rlast_s  = 1'b0;
    rready   = 2'b00;
    arready_s = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    prio  = 0;
  endtask

  // One complete burst as seen from the slave port; called at posedge+1 while the DUT is idle.
  task automatic burst(input bit r0, input bit r1, input int len, input int ar_stall,
                       input int bp_beat, input int bp_cycles, input int abort_beat);
    int w, rx, lasts, nb, stall;
    logic [7:0] exp_id;
    logic [31:0] waddr, d;
    logic [3:0] wlen;
    logic [2:0] wsize;
    logic [1:0] wburst, resp;
    if (r0 && !arvalid[0]) begin new_fields(0, len); arvalid[0] = 1'b1; end
    if (r1 && !arvalid[1]) begin new_fields(1, len); arvalid[1] = 1'b1; end
    w = (arvalid == 2'b11) ? prio : (arvalid[1] ? 1 : 0);
    @(negedge clk);
    chk("ar_grant_win", arready[w], 1'b1);
    chk("ar_grant_lose", arready[1-w], 1'b0);
    chk("ar_idle_arvalid_s", arvalid_s, 1'b0);
    exp_id = {(w == 1) ? TAG_M1 : TAG_M0, arid[w]};
    waddr = araddr[w]; wlen = arlen[w]; wsize = arsize[w]; wburst = arburst[w];
    @(posedge clk);
    #1;
    prio = 1 - w;
    arvalid[w] = 1'b0;
    new_fields(w, 0);
    rvalid_s = 1'b1;
    rready   = 2'b11;
    for (int s = 0; s <= ar_stall; s++) begin
      arready_s = (s == ar_stall);
      @(negedge clk);
      chk("addr_arvalid_s", arvalid_s, 1'b1);
      chk("addr_arid_s", arid_s, exp_id);
      chk("addr_araddr_s", araddr_s, waddr);
      chk("addr_arlen_s", arlen_s, wlen);
      chk("addr_arsize_burst", {arsize_s, arburst_s}, {wsize, wburst});
      chk("addr_arready_m", arready, 2'b00);
      chk("addr_rready_s", rready_s, 1'b0);
      chk("addr_rvalid_m", rvalid_m, 2'b00);
      @(posedge clk);
      #1;
    end
    arready_s = 1'b0;
    rx = 0;
    lasts = 0;
    nb = int'(wlen) + 1;
    for (int b = 0; b < nb; b++) begin
      d = $urandom;
      resp = 2'($urandom);
      rvalid_s = 1'b1;
      rdata_s  = d;
      rresp_s  = resp;
      rlast_s  = (b == nb - 1);
      rid_s    = exp_id;
      rready[1-w] = 1'($urandom);
      if (b == abort_beat) begin
        async_reset(1'b1);
        return;
      end
      stall = (b == bp_beat) ? bp_cycles : 0;
      for (int c = 0; c <= stall; c++) begin
        rready[w] = (c == stall);
        @(negedge clk);
        chk("r_rvalid_own", rvalid_m[w], 1'b1);
        chk("r_rvalid_other", rvalid_m[1-w], 1'b0);
        chk("r_rready_s", rready_s, rready[w]);
        chk("r_rdata", rdata_m[w], d);
        chk("r_rid", rid_m[w], exp_id[3:0]);
        chk("r_rresp", rresp_m[w], resp);
        chk("r_rlast", rlast_m[w], (b == nb - 1));
        chk("r_no_arvalid_s", arvalid_s, 1'b0);
        if (rvalid_m[w] && rready[w]) begin
          rx++;
          if (rlast_m[w]) lasts++;
        end
        @(posedge clk);
        #1;
      end
    end
    rvalid_s = 1'b0;
    rlast_s  = 1'b0;
    rready   = 2'b00;
    chk("burst_beats", 64'(rx), 64'(nb));
    chk("burst_rlast_once", 64'(lasts), 64'd1);
  endtask

  initial begin
    rst_n = 1'b0;
    arvalid = 2'b00; rready = 2'b00; arready_s = 1'b0;
    rvalid_s = 1'b0; rlast_s = 1'b0; rid_s = 8'h00; rdata_s = 32'h0; rresp_s = 2'b00;
    new_fields(0, 0);
    new_fields(1, 0);
    #3;
    chk("por_arvalid_s", arvalid_s, 1'b0);
    chk("por_araddr_s", araddr_s, 32'h0);
    chk("por_arready_m", arready, 2'b00);
    chk("por_rready_s", rready_s, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_no_req_arready", arready, 2'b00);
    chk("idle_no_req_arvalid_s", arvalid_s, 1'b0);
    @(posedge clk);
    #1;

    // Single M0 burst with fixed fields.
    arid[0] = 4'h5; araddr[0] = 32'h0000_1000; arlen[0] = 4'd3;
    arsize[0] = 3'd2; arburst[0] = 2'b01; arvalid[0] = 1'b1;
    burst(1'b1, 1'b0, 3, 0, -1, 0, -1);
    @(negedge clk);
    chk("t1_back_idle", arvalid_s, 1'b0);
    @(posedge clk);
    #1;

    // Simultaneous request straight out of reset: M0 first, M1 waits.
    async_reset(1'b0);
    burst(1'b1, 1'b1, 2, 0, -1, 0, -1);
    burst(1'b0, 1'b1, 1, 0, -1, 0, -1);

    // Continuous requests from both masters alternate.
    for (int i = 0; i < 4; i++) burst(1'b1, 1'b1, $urandom_range(0, 3), 0, -1, 0, -1);

    // R backpressure on M1, AR stall with M0, then reset mid-burst.
    burst(1'b0, 1'b1, 5, 0, 2, 3, -1);
    burst(1'b1, 1'b0, 2, 5, -1, 0, -1);
    burst(1'b1, 1'b0, 7, 0, -1, 0, 2);
    burst(1'b0, 1'b1, 2, 1, -1, 0, -1);

    // Randomized traffic.
    for (int i = 0; i < 24; i++) begin
      bit r0, r1;
      r0 = 1'($urandom);
      r1 = r0 ? 1'($urandom) : 1'b1;
      burst(r0, r1, $urandom_range(0, 7), $urandom_range(0, 3),
            $urandom_range(0, 7), $urandom_range(0, 2), -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/axi_rd_arbiter.md
Name: axi_rd_arbiter

Overview:
- Per-slave read-channel arbiter for the AXI crossbar. One instance sits in front of each slave read port (S0..S5).
- Shares the slave's AR/R channels between master M0 and master M1.
- Grants are round-robin. A grant is held for the whole burst, until the R beat with RLAST is handshaken. R beats are steered back to the granted master only.
- Extends the 4-bit master ID to the 8-bit slave-side ID by prepending a master tag.

Parameters:
- ID_W, 4, master-side ID width (AXI_ID_BITS)
- IDS_W, 8, slave-side ID width (AXI_IDS_BITS); must be ID_W+4
- ADDR_W, 32, address width
- DATA_W, 32, data width
- LEN_W, 4, burst length width
- SIZE_W, 3, burst size width

Ports:
- AXI_CLK_i  in  1  crossbar clock; all logic is on its rising edge
- AXI_RST_i  in  1  asynchronous reset, active-low (0 = reset)
- ARID_Mx_i  in  ID_W  AR ID, x = 0,1
- ARADDR_Mx_i  in  ADDR_W  AR address, x = 0,1
- ARLEN_Mx_i  in  LEN_W  AR burst length, x = 0,1
- ARSIZE_Mx_i  in  SIZE_W  AR burst size, x = 0,1
- ARBURST_Mx_i  in  2  AR burst type, x = 0,1
- ARVALID_Mx_i  in  1  master AR request, x = 0,1
- ARREADY_Mx_o  out  1  AR accept to master x
- RID_Mx_o  out  ID_W  RID_S_i[ID_W-1:0]
- RDATA_Mx_o  out  DATA_W  read data to master x
- RRESP_Mx_o  out  2  read response to master x
- RLAST_Mx_o  out  1  last beat to master x
- RVALID_Mx_o  out  1  read beat valid to master x
- RREADY_Mx_i  in  1  master x ready for R beat
- ARID_S_o  out  IDS_W  {tag, ARID}; tag = 4'b0001 for M0, 4'b0010 for M1
- ARADDR_S_o  out  ADDR_W  latched AR address
- ARLEN_S_o  out  LEN_W  latched AR length
- ARSIZE_S_o  out  SIZE_W  latched AR size
- ARBURST_S_o  out  2  latched AR burst type
- ARVALID_S_o  out  1  AR request to slave
- ARREADY_S_i  in  1  slave AR accept
- RID_S_i  in  IDS_W  slave R ID
- RDATA_S_i  in  DATA_W  slave read data
- RRESP_S_i  in  2  slave read response
- RLAST_S_i  in  1  slave last beat
- RVALID_S_i  in  1  slave read beat valid
- RREADY_S_o  out  1  ready to slave R channel

Behaviour:
- Reset (AXI_RST_i=0, asynchronous):
  - state=IDLE, owner=M0, rr_ptr=M0 (M0 has priority first).
  - All latched AR fields clear to 0.
  - All valid/ready outputs 0. Data outputs 0 or don't-care.
- State machine has three states: IDLE, ADDR, DATA.
- IDLE:
  - grant = requester among {M0,M1} with ARVALID=1. If both request, grant = rr_ptr.
  - ARREADY_Mgrant_o=1 combinationally in IDLE while ARVALID_Mgrant_i=1. The loser's ARREADY stays 0.
  - On that handshake: latch the AR fields and tag, owner<=grant, rr_ptr<=other master, go to ADDR.
  - With no request, stay in IDLE and keep rr_ptr.
- ADDR:
  - ARVALID_S_o=1 with the latched fields, stable until ARREADY_S_i=1.
  - On the handshake, go to DATA.
  - Both master ARREADYs are 0.
  - Latency: master handshake at cycle N gives ARVALID_S_o=1 at cycle N+1.
- DATA, combinational R routing:
  - RVALID_Mowner_o=RVALID_S_i, RREADY_S_o=RREADY_Mowner_i.
  - RDATA, RRESP, RLAST and RID[ID_W-1:0] are forwarded to the owner.
  - The non-owner's RVALID is 0.
  - A beat with RVALID_S_i & RREADY_S_o & RLAST_S_i moves to IDLE on the next edge. The new arbitration can accept an AR in that IDLE cycle.
- Outside DATA: RREADY_S_o=0 and both RVALID_Mx_o=0. A slave beat arriving early is held off by the slave.
- The arbiter does not check RID_S_i tag bits; routing uses the owner only.
- Only one outstanding burst per slave; no interleaving.
- ARVALID_Mx withdrawn in IDLE before handshake: no grant, no latch, rr_ptr unchanged.
- Simultaneous requests: each handshake flips rr_ptr, so continuous requests from both masters alternate M0,M1,M0,...
- Reset asserted mid-burst: immediately returns to IDLE with all valids 0. The in-flight burst is abandoned; the slave and masters are reset with it.

Decomposition:
- Shared package axi_xbar_pkg holds:
  - the master tag constants TAG_M0=4'b0001 and TAG_M1=4'b0010;
  - the state enum {IDLE, ADDR, DATA};
  - the ar_pkt_t struct (id, addr, len, size, burst).
- One sub-module, rr_arb2: a 2-way round-robin grant with priority pointer and an update-on-accept input. The write-path arbiter reuses it.

Test Plan:
1. Reset then M0 ARVALID, ARADDR=0x0000_1000, ARLEN=3, ARID=4'h5, slave ARREADY=1 -> ARVALID_S high 1 cycle after M0 handshake. ARID_S=8'h15. 4 beats to M0 with RID_M0=4'h5. IDLE after RLAST.
2. M0 and M1 request the same cycle out of reset, both held -> M0 granted first. M1 granted after M0's RLAST handshake. M1 ARID_S tag = 4'b0010.
3. Back-to-back continuous requests from both masters for 4 bursts -> grant order M0,M1,M0,M1. No overlap of ARVALID_S with a DATA phase.
4. R backpressure: RREADY_M1=0 for 3 cycles mid-burst with RVALID_S=1 -> RREADY_S=0 those cycles. No beat lost or duplicated. RLAST delivered once.
5. Slave ARREADY_S low for 5 cycles -> ARADDR_S and ARID_S stable. Both ARREADY_Mx=0 throughout.
6. Assert AXI_RST_i=0 during beat 2 of an ARLEN=7 burst -> all outputs 0 asynchronously. After release, a fresh M1 request is granted normally.
